// File: rtl/mem_port_arb.sv
// Shares one memory port between weight reads, input-data reads and result writes, with burst
// locking and an in-order read tag FIFO. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arb #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wt_rd_req,
  input  logic [AW-1:0] wt_rd_addr,
  output logic          wt_rd_gnt,
  output logic          wt_rd_valid,
  output logic [DW-1:0] wt_rd_data,
  input  logic          dat_rd_req,
  input  logic [AW-1:0] dat_rd_addr,
  output logic          dat_rd_gnt,
  output logic          dat_rd_valid,
  output logic [DW-1:0] dat_rd_data,
  input  logic          dst_wr_req,
  input  logic [AW-1:0] dst_wr_addr,
  input  logic [DW-1:0] dst_wr_data,
  output logic          dst_wr_gnt,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic          err_unexp_rsp
);
  // state    | meaning
  // OWN_NONE | port idle, re-arbitrated every cycle
  // OWN_WT   | weight reads own the port
  // OWN_DAT  | input-data reads own the port
  // OWN_DST  | result writes own the port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WT   = 2'd1,
    OWN_DAT  = 2'd2,
    OWN_DST  = 2'd3
  } owner_t;

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [7:0]    LAST_BEAT = 8'(BURST_LEN - 1);

  owner_t        r_owner;
  owner_t        w_next;
  logic [7:0]    r_beat_cnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [1:0]    r_tags [MAX_OUTSTANDING];
  logic          r_err;
  logic [3:0]    w_req_vec;
  logic          w_owner_req;
  logic          w_full;
  logic          w_empty;
  logic          w_mem_req;
  logic          w_gnt_any;
  logic          w_last_beat;
  logic          w_rearb;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head;

  // Indexed by owner encoding; slot 0 (NONE) never requests.
  assign w_req_vec   = {dst_wr_req, dat_rd_req, wt_rd_req, 1'b0};
  assign w_owner_req = w_req_vec[r_owner];
  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_mem_req   = (r_owner != OWN_NONE) & w_owner_req & ((r_owner == OWN_DST) | ~w_full);
  assign w_gnt_any   = w_mem_req & mem_gnt;
  assign w_last_beat = w_gnt_any & (r_beat_cnt == LAST_BEAT);
  assign w_rearb     = (r_owner == OWN_NONE) | ~w_owner_req | w_last_beat;
  assign w_push      = w_gnt_any & (r_owner != OWN_DST);
  assign w_pop       = mem_rvalid & ~w_empty;
  assign w_head      = r_tags[r_rptr];

`ifdef MEM_ARB_RR_EN
  owner_t r_last;

  // Channel visited 'step' places after 'last' in the cycle WT->DAT->DST->WT.
  function automatic logic [1:0] rr_cand(input logic [1:0] last, input int step);
    int t;
    t = (int'(last) - 1 + step) % 3 + 1;
    return 2'(t);
  endfunction

  // Scanned farthest-first so the nearest requesting channel wins.
  always_comb begin
    w_next = OWN_NONE;
    for (int i = 3; i >= 1; i--) begin
      if (w_req_vec[rr_cand(r_last, i)]) w_next = owner_t'(rr_cand(r_last, i));
    end
  end
`else
  always_comb begin
    w_next = OWN_NONE;
    if (dst_wr_req)      w_next = OWN_DST;
    else if (wt_rd_req)  w_next = OWN_WT;
    else if (dat_rd_req) w_next = OWN_DAT;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_beat_cnt <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last     <= OWN_DST;
`endif
    end else begin
      if (w_rearb) begin
        r_owner    <= w_next;
        r_beat_cnt <= '0;
`ifdef MEM_ARB_RR_EN
        if (w_next != OWN_NONE) r_last <= w_next;
`endif
      end else if (w_gnt_any) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end

      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (mem_rvalid & w_empty) r_err <= 1'b1;
    end
  end

  // Tag payload needs no reset: the count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wptr] <= r_owner;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_owner)
      OWN_WT:  mem_addr = wt_rd_addr;
      OWN_DAT: mem_addr = dat_rd_addr;
      OWN_DST: begin
        mem_addr  = dst_wr_addr;
        mem_wdata = dst_wr_data;
      end
      default: ;
    endcase
  end

  assign mem_req       = w_mem_req;
  assign mem_we        = (r_owner == OWN_DST);
  assign wt_rd_gnt     = w_gnt_any & (r_owner == OWN_WT);
  assign dat_rd_gnt    = w_gnt_any & (r_owner == OWN_DAT);
  assign dst_wr_gnt    = w_gnt_any & (r_owner == OWN_DST);
  assign wt_rd_valid   = w_pop & (w_head == 2'(OWN_WT));
  assign dat_rd_valid  = w_pop & (w_head == 2'(OWN_DAT));
  assign wt_rd_data    = mem_rdata;
  assign dat_rd_data   = mem_rdata;
  assign owner         = r_owner;
  assign err_unexp_rsp = r_err;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: a cycle vector table plus hand-written multi-cycle
// sequences. Builds with or without MEM_ARB_RR_EN.
module tb_mem_port_arb;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;
`ifdef MEM_ARB_RR_EN
  localparam int BL = 2;
`else
  localparam int BL = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wt_rd_req, dat_rd_req, dst_wr_req;
  logic [AW-1:0] wt_rd_addr, dat_rd_addr, dst_wr_addr;
  logic [DW-1:0] dst_wr_data;
  logic          wt_rd_gnt, dat_rd_gnt, dst_wr_gnt;
  logic          wt_rd_valid, dat_rd_valid;
  logic [DW-1:0] wt_rd_data, dat_rd_data;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    owner;
  logic          err_unexp_rsp;

  mem_port_arb #(.AW(AW), .DW(DW), .BURST_LEN(BL), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .wt_rd_req(wt_rd_req), .wt_rd_addr(wt_rd_addr), .wt_rd_gnt(wt_rd_gnt),
    .wt_rd_valid(wt_rd_valid), .wt_rd_data(wt_rd_data),
    .dat_rd_req(dat_rd_req), .dat_rd_addr(dat_rd_addr), .dat_rd_gnt(dat_rd_gnt),
    .dat_rd_valid(dat_rd_valid), .dat_rd_data(dat_rd_data),
    .dst_wr_req(dst_wr_req), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .dst_wr_gnt(dst_wr_gnt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  req;     // {dst, dat, wt}
    logic        gnt;
    logic        rv;
    logic [1:0]  e_owner;
    logic        e_req;
    logic        e_we;
    logic [2:0]  e_gnt;   // {dst, dat, wt}
    logic [1:0]  e_val;   // {dat, wt}
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] rq, input logic g, input logic rv, input logic [1:0] eo,
                     input logic er, input logic ew, input logic [2:0] eg, input logic [1:0] ev,
                     input logic [31:0] ea);
    vec_t v;
    v.req = rq; v.gnt = g; v.rv = rv; v.e_owner = eo; v.e_req = er; v.e_we = ew;
    v.e_gnt = eg; v.e_val = ev; v.e_addr = ea;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    wt_rd_req = 0; dat_rd_req = 0; dst_wr_req = 0;
    wt_rd_addr = 32'h1000; dat_rd_addr = 32'h2000; dst_wr_addr = 32'h3000;
    dst_wr_data = 32'h0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h55;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ng, nv, nd, last_g, first_v, cur, ef;
    logic rv_q [0:99];
    logic [31:0] rd_q [0:99];
    int iss[$];
    int seq [0:5];

    // ---------------- reset state, with every input active ----------------
    idle_inputs();
    rst = 1;
    wt_rd_req = 1; dat_rd_req = 1; dst_wr_req = 1; mem_gnt = 1; mem_rvalid = 1;
    @(posedge clk); #1;
    chk("rst owner", owner, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst gnts", {dst_wr_gnt, dat_rd_gnt, wt_rd_gnt}, 0);
    chk("rst valids", {dat_rd_valid, wt_rd_valid}, 0);
    chk("rst err", err_unexp_rsp, 0);

    // ---------------- cycle vector table ----------------
`ifdef MEM_ARB_RR_EN
    add(3'b111,1,0, 2'd0,0,0,3'b000,2'b00,32'h0);
    add(3'b111,1,0, 2'd1,1,0,3'b001,2'b00,32'h1000);
    add(3'b111,1,0, 2'd1,1,0,3'b001,2'b00,32'h1000);
    add(3'b111,1,1, 2'd2,1,0,3'b010,2'b01,32'h2000);
    add(3'b111,1,1, 2'd2,1,0,3'b010,2'b01,32'h2000);
    add(3'b111,1,1, 2'd3,1,1,3'b100,2'b10,32'h3000);
    add(3'b111,1,1, 2'd3,1,1,3'b100,2'b10,32'h3000);
    add(3'b111,1,0, 2'd1,1,0,3'b001,2'b00,32'h1000);
    add(3'b000,1,0, 2'd1,0,0,3'b000,2'b00,32'h0);
`else
    add(3'b110,1,0, 2'd0,0,0,3'b000,2'b00,32'h0);
    add(3'b110,1,0, 2'd3,1,1,3'b100,2'b00,32'h3000);
    add(3'b110,1,0, 2'd3,1,1,3'b100,2'b00,32'h3000);
    add(3'b010,1,0, 2'd3,0,1,3'b000,2'b00,32'h0);
    add(3'b010,1,0, 2'd2,1,0,3'b010,2'b00,32'h2000);
    add(3'b010,0,0, 2'd2,1,0,3'b000,2'b00,32'h2000);
    add(3'b001,1,1, 2'd2,0,0,3'b000,2'b10,32'h0);
    add(3'b001,1,0, 2'd1,1,0,3'b001,2'b00,32'h1000);
    add(3'b000,1,1, 2'd1,0,0,3'b000,2'b01,32'h0);
    add(3'b101,1,0, 2'd0,0,0,3'b000,2'b00,32'h0);
    add(3'b101,1,0, 2'd3,1,1,3'b100,2'b00,32'h3000);
    add(3'b001,1,0, 2'd3,0,1,3'b000,2'b00,32'h0);
    add(3'b001,1,0, 2'd1,1,0,3'b001,2'b00,32'h1000);
    add(3'b000,1,1, 2'd1,0,0,3'b000,2'b01,32'h0);
    add(3'b000,1,0, 2'd0,0,0,3'b000,2'b00,32'h0);
`endif
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      {dst_wr_req, dat_rd_req, wt_rd_req} = tbl[i].req;
      mem_gnt = tbl[i].gnt;
      mem_rvalid = tbl[i].rv;
      @(negedge clk);
      chk($sformatf("vec%0d owner", i), owner, tbl[i].e_owner);
      chk($sformatf("vec%0d mem_req", i), mem_req, tbl[i].e_req);
      chk($sformatf("vec%0d mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("vec%0d gnt", i), {dst_wr_gnt, dat_rd_gnt, wt_rd_gnt}, tbl[i].e_gnt);
      chk($sformatf("vec%0d valid", i), {dat_rd_valid, wt_rd_valid}, tbl[i].e_val);
      if (tbl[i].e_req) chk($sformatf("vec%0d addr", i), mem_addr, tbl[i].e_addr);
      @(posedge clk); #1;
    end

    // ---------------- single weight burst, read latency 2 ----------------
    for (int i = 0; i < 100; i++) begin rv_q[i] = 0; rd_q[i] = 0; end
    do_reset();
    mem_gnt = 1;
    ng = 0; nv = 0; nd = 0; last_g = -1; first_v = -1;
    for (int c = 0; c < 30; c++) begin
      wt_rd_req  = (ng < 20);
      wt_rd_addr = 32'h100 + 32'(ng);
      mem_rvalid = rv_q[c];
      mem_rdata  = rd_q[c];
      @(negedge clk);
      if (c == 1)  chk("burst owner cycle1", owner, 1);
      if (c == 17) chk("burst owner after expiry", owner, 1);
      if (c == 17) chk("burst regrant no bubble", wt_rd_gnt, 1);
      if (wt_rd_gnt) begin
        chk($sformatf("burst addr%0d", ng), mem_addr, 32'h100 + 32'(ng));
        rv_q[c+2] = 1;
        rd_q[c+2] = (32'h100 + 32'(ng)) ^ 32'hCAFE0000;
        ng++;
        last_g = c;
      end
      if (dat_rd_valid) nd++;
      if (wt_rd_valid) begin
        chk($sformatf("burst data%0d", nv), wt_rd_data, (32'h100 + 32'(nv)) ^ 32'hCAFE0000);
        if (first_v < 0) first_v = c;
        nv++;
      end
      @(posedge clk); #1;
    end
    chk("burst grant count", ng, 20);
    chk("burst last grant cycle", last_g, 20);
    chk("burst valid count", nv, 20);
    chk("burst first valid cycle", first_v, 3);
    chk("burst stray dat valids", nd, 0);

    // ---------------- FIFO full ----------------
    do_reset();
    mem_gnt = 1;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      wt_rd_req  = 1;
      wt_rd_addr = 32'h200 + 32'(ng);
      @(negedge clk);
      if (wt_rd_gnt) ng++;
      if (c == 7) chk("full mem_req stalled", mem_req, 0);
      @(posedge clk); #1;
    end
    chk("full grant count", ng, 4);
    wt_rd_req = 0; dst_wr_req = 1; dst_wr_addr = 32'h3000; dst_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("full switch owner", owner, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full dst gnt", dst_wr_gnt, 1);
    chk("full dst we", mem_we, 1);
    chk("full dst wdata", mem_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    dst_wr_req = 0; wt_rd_req = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full wt owner again", owner, 1);
    chk("full wt still blocked", mem_req, 0);
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("full pop valid", {dat_rd_valid, wt_rd_valid}, 2'b01);
    chk("full no gnt during pop", wt_rd_gnt, 0);
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(negedge clk);
    chk("full one more gnt", wt_rd_gnt, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full blocked again", mem_req, 0);
    @(posedge clk); #1;
    wt_rd_req = 0;

    // ---------------- interleaved WT/DAT, read latency 3 ----------------
    for (int i = 0; i < 100; i++) begin rv_q[i] = 0; rd_q[i] = 0; end
    seq[0] = 1; seq[1] = 2; seq[2] = 1; seq[3] = 2; seq[4] = 1; seq[5] = 2;
    do_reset();
    mem_gnt = 1;
    cur = 0; nv = 0;
    for (int c = 0; c < 80 && (cur < 6 || nv < 6); c++) begin
      wt_rd_req   = (cur < 6) && (seq[cur] == 1);
      dat_rd_req  = (cur < 6) && (seq[cur] == 2);
      wt_rd_addr  = 32'h400 + 32'(cur);
      dat_rd_addr = 32'h400 + 32'(cur);
      mem_rvalid  = rv_q[c];
      mem_rdata   = rd_q[c];
      @(negedge clk);
      if (wt_rd_gnt || dat_rd_gnt) begin
        rv_q[c+3] = 1;
        rd_q[c+3] = 32'(cur);
        iss.push_back(seq[cur]);
        cur++;
      end
      if (mem_rvalid && iss.size() > 0) begin
        ef = iss.pop_front();
        chk($sformatf("il steer%0d", nv), {dat_rd_valid, wt_rd_valid}, (ef == 2) ? 2'b10 : 2'b01);
        chk($sformatf("il data%0d", nv), (ef == 2) ? dat_rd_data : wt_rd_data, 32'(nv));
        nv++;
      end
      @(posedge clk); #1;
    end
    wt_rd_req = 0; dat_rd_req = 0;
    chk("il issued", cur, 6);
    chk("il returned", nv, 6);

    // ---------------- unexpected response ----------------
    mem_rvalid = 1;
    @(negedge clk);
    chk("unexp no valid", {dat_rd_valid, wt_rd_valid}, 0);
    chk("unexp err before edge", err_unexp_rsp, 0);
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(negedge clk);
    chk("unexp err set", err_unexp_rsp, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("unexp err sticky", err_unexp_rsp, 1);
    rst = 1;
    #1;
    chk("unexp err cleared by rst", err_unexp_rsp, 0);
    @(posedge clk); #1;
    rst = 0;

    // ---------------- reset mid-burst with 3 reads outstanding ----------------
    do_reset();
    mem_gnt = 1;
    ng = 0;
    while (ng < 3 && ng >= 0) begin
      wt_rd_req = 1;
      @(negedge clk);
      if (wt_rd_gnt) ng++;
      @(posedge clk); #1;
      if (owner == 2'd0 && ng == 0 && $time > 100000) ng = -1;
    end
    chk("midrst outstanding", ng, 3);
    #1;
    chk("midrst req before rst", mem_req, 1);
    rst = 1;
    #1;
    chk("midrst owner", owner, 0);
    chk("midrst mem_req", mem_req, 0);
    chk("midrst gnt", wt_rd_gnt, 0);
    @(posedge clk); #1;
    rst = 0; wt_rd_req = 0;
    mem_rvalid = 1;
    @(negedge clk);
    chk("midrst stray no valid", {dat_rd_valid, wt_rd_valid}, 0);
    @(posedge clk); #1;
    mem_rvalid = 0;
    @(negedge clk);
    chk("midrst stray err", err_unexp_rsp, 1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
